div_seq: RTL and testbench

- Next-generation sequential integer divider for the eJ32 ALU, replacing the fixed unsigned restoring divider.
- Adds signed (JVM idiv/irem truncating) and unsigned modes, a start/done handshake, and an explicit state machine with a sign-fix stage.
- Adds a fast divide-by-zero path and an optional radix-4 datapath.
- Sits beside mult/shifter in the execute stage; the core stalls while busy=1.

---
 rtl/div_seq.sv | 148 ++++++++++++++
 tb/tb_div_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential signed/unsigned integer divider with start/done handshake and a sign-fix stage.
// Optional macro DIV_RADIX4_EN retires two quotient bits per clock instead of one.
module div_seq #(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  output logic           busy,
  output logic           done,
  output logic           dbz,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r
);

  localparam int CW = $clog2(DSZ);
`ifdef DIV_RADIX4_EN
  localparam logic [CW-1:0] CNT_INIT = CW'(DSZ / 2 - 1);
`else
  localparam logic [CW-1:0] CNT_INIT = CW'(DSZ - 1);
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_reg;
  logic [DSZ-1:0] rem_reg;
  logic [DSZ-1:0] quo_reg;
  logic [DSZ-1:0] ymag_reg;
  logic [DSZ-1:0] x_reg;
  logic           neg_q_reg;
  logic           neg_r_reg;
  logic           zero_div_reg;
  logic [CW-1:0]  cnt_reg;

  logic [DSZ-1:0] x_mag;
  logic [DSZ-1:0] y_mag;
  logic [DSZ-1:0] rem_next;
  logic [DSZ-1:0] quo_next;

  // The restored remainder is always below the divisor, so only the shifted
  // compare needs the extra bit; the stored remainder stays DSZ wide.
  function automatic logic [2*DSZ-1:0] restore_step(
    input logic [DSZ-1:0] rem_in,
    input logic [DSZ-1:0] quo_in,
    input logic [DSZ-1:0] d
  );
    logic [DSZ:0] sh;
    sh = {rem_in, quo_in[DSZ-1]};
    if (sh >= {1'b0, d})
      return {DSZ'(sh - {1'b0, d}), quo_in[DSZ-2:0], 1'b1};
    else
      return {sh[DSZ-1:0], quo_in[DSZ-2:0], 1'b0};
  endfunction

  always_comb begin
    x_mag = (sgn && x[DSZ-1]) ? -x : x;
    y_mag = (sgn && y[DSZ-1]) ? -y : y;
  end

`ifdef DIV_RADIX4_EN
  logic [2*DSZ-1:0] step1;
  logic [2*DSZ-1:0] step2;

  always_comb begin
    step1    = restore_step(rem_reg, quo_reg, ymag_reg);
    step2    = restore_step(step1[2*DSZ-1:DSZ], step1[DSZ-1:0], ymag_reg);
    rem_next = step2[2*DSZ-1:DSZ];
    quo_next = step2[DSZ-1:0];
  end
`else
  logic [2*DSZ-1:0] step1;

  always_comb begin
    step1    = restore_step(rem_reg, quo_reg, ymag_reg);
    rem_next = step1[2*DSZ-1:DSZ];
    quo_next = step1[DSZ-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      dbz          <= 1'b0;
      q            <= '0;
      r            <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      ymag_reg     <= '0;
      x_reg        <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      zero_div_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            x_reg <= x;
            if (y == '0) begin
              zero_div_reg <= 1'b1;
              state_reg    <= FIX;
            end else begin
              zero_div_reg <= 1'b0;
              rem_reg      <= '0;
              quo_reg      <= x_mag;
              ymag_reg     <= y_mag;
              neg_q_reg    <= sgn & (x[DSZ-1] ^ y[DSZ-1]);
              neg_r_reg    <= sgn & x[DSZ-1];
              cnt_reg      <= CNT_INIT;
              state_reg    <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0)
            state_reg <= FIX;
        end
        FIX: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
          if (zero_div_reg) begin
            dbz <= 1'b1;
            q   <= '1;
            r   <= x_reg;
          end else begin
            // Negating zero gives zero, so no extra guard is needed here.
            dbz <= 1'b0;
            q   <= neg_q_reg ? -quo_reg : quo_reg;
            r   <= neg_r_reg ? -rem_reg : rem_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed steps, scoreboard queue, per-cycle busy check.
module tb_div_seq;

  localparam int DSZ = 32;
`ifdef DIV_RADIX4_EN
  localparam int LAT = DSZ / 2 + 1;
`else
  localparam int LAT = DSZ + 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           sgn = 1'b0;
  logic [DSZ-1:0] x = '0;
  logic [DSZ-1:0] y = '0;
  logic           busy;
  logic           done;
  logic           dbz;
  logic [DSZ-1:0] q;
  logic [DSZ-1:0] r;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  typedef struct {
    logic [DSZ-1:0] q;
    logic [DSZ-1:0] r;
    logic           dbz;
    int             lat;
    int             start_cyc;
  } exp_t;

  exp_t sb[$];

  div_seq #(.DSZ(DSZ)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sgn  (sgn),
    .x    (x),
    .y    (y),
    .busy (busy),
    .done (done),
    .dbz  (dbz),
    .q    (q),
    .r    (r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DSZ-1:0] obs, input logic [DSZ-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [DSZ-1:0] a, input logic [DSZ-1:0] b);
    exp_t   e;
    longint xs;
    longint ys;
    e.start_cyc = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.dbz = 1'b0; e.lat = LAT;
      if (s) begin
        xs = $signed(a);
        ys = $signed(b);
        e.q = DSZ'(xs / ys);
        e.r = DSZ'(xs % ys);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  // Called at a negedge while the divider is idle; returns at the next negedge.
  task automatic issue(input logic s, input logic [DSZ-1:0] a, input logic [DSZ-1:0] b);
    exp_t e;
    e = model(s, a, b);
    sgn = s; x = a; y = b; start = 1'b1;
    @(posedge clk);
    #1;
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, DSZ'(seen), DSZ'(1));
  endtask

  task automatic run(input string tag, input logic s, input logic [DSZ-1:0] a, input logic [DSZ-1:0] b);
    $display("op %s: sgn=%0d x=%h y=%h", tag, s, a, b);
    issue(s, a, b);
    wait_done(tag);
    @(negedge clk);
  endtask

  // Scoreboard consumer plus per-cycle busy expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    if (mon_en) begin
      exp_busy = (sb.size() > 0) && (done !== 1'b1);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", DSZ'(1), DSZ'(0));
        end else begin
          e = sb.pop_front();
          chk("q", q, e.q);
          chk("r", r, e.r);
          chk("dbz", DSZ'(dbz), DSZ'(e.dbz));
          chk("latency", DSZ'(cyc - e.start_cyc), DSZ'(e.lat));
          $display("result q=%h r=%h dbz=%0d after %0d cycles", q, r, dbz, cyc - e.start_cyc);
        end
      end
      chk("busy", DSZ'(busy), DSZ'(exp_busy));
    end
  end

  initial begin
    logic [DSZ-1:0] held_q;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", DSZ'(busy), DSZ'(0));
    chk("rst_done", DSZ'(done), DSZ'(0));
    chk("rst_dbz", DSZ'(dbz), DSZ'(0));
    chk("rst_q", q, '0);
    chk("rst_r", r, '0);
    mon_en = 1'b1;
    @(negedge clk);

    run("u100_7", 1'b0, 32'd100, 32'd7);
    run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run("s_m6_m3", 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFD);
    run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run("u_small", 1'b0, 32'd3, 32'd10);
    run("dbz", 1'b0, 32'h1234_5678, 32'd0);
    run("after_dbz", 1'b0, 32'd50, 32'd5);

    held_q = q;
    repeat (4) @(negedge clk);
    chk("hold_q", q, held_q);

    for (int i = 0; i < 6; i++) begin
      logic [DSZ-1:0] a;
      logic [DSZ-1:0] b;
      a = $urandom;
      b = (i % 2 == 0) ? DSZ'($urandom_range(1, 1000)) : $urandom;
      if (b == '0) b = 32'd3;
      run("rand", i[0], a, b);
    end

    $display("op ignore: sgn=1 x=%h y=%h with starts during busy", -32'sd1000, 32'd7);
    issue(1'b1, -32'sd1000, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sgn = 1'b0; x = $urandom; y = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("ignore");
    @(negedge clk);

    $display("op b2b: two divisions, second started in done cycle");
    issue(1'b0, 32'd1000, 32'd33);
    wait_done("b2b_first");
    issue(1'b1, 32'hFFFF_FC00, 32'd9);
    wait_done("b2b_second");
    @(negedge clk);

    $display("op reset_abort: rst during CALC");
    issue(1'b0, 32'd1000000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", DSZ'(busy), DSZ'(0));
    chk("abort_done", DSZ'(done), DSZ'(0));
    chk("abort_dbz", DSZ'(dbz), DSZ'(0));
    chk("abort_q", q, '0);
    chk("abort_r", r, '0);
    repeat (40) @(negedge clk);
    run("post_abort", 1'b0, 32'd100, 32'd7);

    repeat (5) @(negedge clk);
    chk("sb_empty", DSZ'(sb.size()), DSZ'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
